// File: rtl/ahb_cmd_master.sv
// ahb_cmd_master
//   AHB-Lite single-transfer master. Takes valid/ready commands, issues NONSEQ/SINGLE
//   transfers with pipelined address and data phases, handles wait states and the
//   two-cycle ERROR response, and returns in-order responses through a small FIFO.
//
// Ports
//   HCLK, HRESET          clock, synchronous active-high reset
//   cmd_*                 command channel (valid/ready, write, addr, size, wdata)
//   rsp_*                 response channel (valid/ready, rdata, err, write echo)
//   HADDR..HWDATA         AHB-Lite master outputs, all driven from flops
//   HRDATA, HREADY, HRESP AHB-Lite slave returns
module ahb_cmd_master #(
   parameter int unsigned AWIDTH    = 10,
   parameter int unsigned RSP_DEPTH = 4,
   parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [AWIDTH-1:0] cmd_addr,
   input  logic [1:0]        cmd_size,
   input  logic [31:0]       cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              rsp_write,
   output logic [AWIDTH-1:0] HADDR,
   output logic [1:0]        HTRANS,
   output logic              HWRITE,
   output logic [2:0]        HSIZE,
   output logic [2:0]        HBURST,
   output logic              HMASTLOCK,
   output logic [3:0]        HPROT,
   output logic [31:0]       HWDATA,
   input  logic [31:0]       HRDATA,
   input  logic              HREADY,
   input  logic              HRESP
);

   localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
   localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

   typedef enum logic [1:0] {TransIdle = 2'b00, TransNonseq = 2'b10} htrans_e;

   // Address slot
   logic              slot_valid_q, slot_write_q, slot_mis_q;
   logic [AWIDTH-1:0] slot_addr_q;
   logic [1:0]        slot_size_q;
   logic [31:0]       slot_wdata_q;
   htrans_e           htrans_q, htrans_d;
   // Set while the slot's transfer is withdrawn during the second ERROR cycle
   logic              cancel_q, cancel_d;

   // Data-phase register
   logic              dp_valid_q, dp_write_q, dp_mis_q;
   logic [31:0]       hwdata_q;

   // Response FIFO
   logic [31:0]       fifo_rdata_q [RSP_DEPTH];
   logic              fifo_err_q   [RSP_DEPTH];
   logic              fifo_write_q [RSP_DEPTH];
   logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]     cnt_q;

   logic        err1, slot_adv, slot_free, dp_done, push, pop, accept, cmd_mis;
   logic [31:0] outstanding;
   logic [31:0] push_rdata;
   logic        push_err;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      err1      = dp_valid_q & HRESP & ~HREADY;
      slot_adv  = slot_valid_q & HREADY & ~cancel_q;
      slot_free = ~slot_valid_q | slot_adv;
      dp_done   = dp_valid_q & HREADY;
      push      = dp_done;
      rsp_valid = (cnt_q != '0);
      pop       = rsp_valid & rsp_ready;
      // Everything in flight, crediting a response leaving this cycle
      outstanding = 32'(slot_valid_q) + 32'(dp_valid_q) + 32'(cnt_q) - 32'(pop);
      cmd_ready   = ~HRESET & slot_free & (outstanding < RSP_DEPTH);
      accept      = cmd_valid & cmd_ready;

      unique case (cmd_size)
         2'd0:    cmd_mis = 1'b0;
         2'd1:    cmd_mis = cmd_addr[0];
         2'd2:    cmd_mis = (cmd_addr[1:0] != 2'b00);
         default: cmd_mis = 1'b1;
      endcase

      push_rdata = (~dp_write_q & ~dp_mis_q & ~HRESP) ? HRDATA : 32'h0;
      push_err   = HRESP | dp_mis_q;
   end

   always_comb begin
      htrans_d = htrans_q;
      cancel_d = cancel_q;
      if (accept) begin
         htrans_d = cmd_mis ? TransIdle : TransNonseq;
         cancel_d = 1'b0;
      end else if (slot_adv) begin
         htrans_d = TransIdle;
      end else if (err1 && htrans_q == TransNonseq) begin
         // Withdraw the pending address during ERROR cycle 2, re-issue afterwards
         htrans_d = TransIdle;
         cancel_d = 1'b1;
      end else if (cancel_q && HREADY) begin
         htrans_d = TransNonseq;
         cancel_d = 1'b0;
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         slot_valid_q <= 1'b0;
         slot_write_q <= 1'b0;
         slot_mis_q   <= 1'b0;
         slot_addr_q  <= '0;
         slot_size_q  <= '0;
         slot_wdata_q <= '0;
         htrans_q     <= TransIdle;
         cancel_q     <= 1'b0;
         dp_valid_q   <= 1'b0;
         dp_write_q   <= 1'b0;
         dp_mis_q     <= 1'b0;
         hwdata_q     <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         cnt_q        <= '0;
         for (int i = 0; i < int'(RSP_DEPTH); i++) begin
            fifo_rdata_q[i] <= '0;
            fifo_err_q[i]   <= 1'b0;
            fifo_write_q[i] <= 1'b0;
         end
      end else begin
         htrans_q <= htrans_d;
         cancel_q <= cancel_d;

         if (accept) begin
            slot_valid_q <= 1'b1;
            slot_write_q <= cmd_write;
            slot_mis_q   <= cmd_mis;
            slot_addr_q  <= cmd_addr;
            slot_size_q  <= cmd_size;
            slot_wdata_q <= cmd_wdata;
         end else if (slot_adv) begin
            slot_valid_q <= 1'b0;
         end

         if (slot_adv) begin
            dp_valid_q <= 1'b1;
            dp_write_q <= slot_write_q;
            dp_mis_q   <= slot_mis_q;
            hwdata_q   <= slot_wdata_q;
         end else if (dp_done) begin
            dp_valid_q <= 1'b0;
         end

         if (push) begin
            fifo_rdata_q[wr_ptr_q] <= push_rdata;
            fifo_err_q[wr_ptr_q]   <= push_err;
            fifo_write_q[wr_ptr_q] <= dp_write_q;
            wr_ptr_q               <= ptr_inc(wr_ptr_q);
         end
         if (pop) begin
            rd_ptr_q <= ptr_inc(rd_ptr_q);
         end
         if (push && !pop) begin
            cnt_q <= cnt_q + CW'(1);
         end else if (!push && pop) begin
            cnt_q <= cnt_q - CW'(1);
         end
      end
   end

   always_comb begin
      rsp_rdata = rsp_valid ? fifo_rdata_q[rd_ptr_q] : 32'h0;
      rsp_err   = rsp_valid & fifo_err_q[rd_ptr_q];
      rsp_write = rsp_valid & fifo_write_q[rd_ptr_q];
   end

   assign HADDR     = slot_addr_q;
   assign HTRANS    = htrans_q;
   assign HWRITE    = slot_write_q;
   assign HSIZE     = {1'b0, slot_size_q};
   assign HBURST    = 3'b000;
   assign HMASTLOCK = 1'b0;
   assign HPROT     = HPROT_VAL;
   assign HWDATA    = hwdata_q;

endmodule
